// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the PC, fetches from a combinational ROM into a
// DEPTH-entry prefetch queue and hands entries to decode over valid/ready.
// Taken branches and jumps redirect the PC and flush the queue.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_stall/perf_flush counters.
module fetch_queue_unit #(
  parameter int unsigned   PC_W     = 32,
  parameter int unsigned   INSTR_W  = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc4,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_base_pc4,
  input  logic [15:0]        br_imm16,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_base_pc4,
  input  logic [25:0]        jump_tgt26
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_flush
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned EXT_W = (PC_W > 18) ? PC_W : 18;

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [PC_W-1:0]    pc_mem_d    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               redirect;
  logic               pop;
  logic               push;
  logic [EXT_W-1:0]   br_off;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    jump_target;
  logic [PC_W-1:0]    redirect_target;

  // Jump target: region bits come from the jump's pc+4 only when the PC is wide enough
  if (PC_W > 28) begin : g_jump_wide
    logic unused_jump_low;
    assign unused_jump_low = ^jump_base_pc4[27:0];
    assign jump_target     = {jump_base_pc4[PC_W-1:28], jump_tgt26, 2'b00};
  end else begin : g_jump_narrow
    logic        unused_jump_base;
    logic [27:0] jump_word;
    assign unused_jump_base = ^jump_base_pc4;
    assign jump_word        = {jump_tgt26, 2'b00};
    assign jump_target      = jump_word[PC_W-1:0];
  end

  // Redirect selection and queue handshake decode
  always_comb begin
    br_off          = EXT_W'($signed({br_imm16, 2'b00}));
    br_target       = br_base_pc4 + br_off[PC_W-1:0];
    redirect        = br_taken | jump;
    redirect_target = jump ? jump_target : br_target;
    pop             = out_valid & out_ready;
    push            = ~redirect & ((count_q != CNT_W'(DEPTH)) | pop);
  end

  // Next-state for PC, pointers, occupancy and queue storage
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect) begin
      fetch_pc_d = redirect_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        fetch_pc_d            = fetch_pc_q + PC_W'(4);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue payload storage needs no reset; occupancy gates its visibility
  always_ff @(posedge clock) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  // Head of queue drives decode; empty queue presents zeros
  always_comb begin
    imem_addr = fetch_pc_q;
    out_valid = (count_q != '0);
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_pc4   = out_valid ? (pc_mem_q[rd_ptr_q] + PC_W'(4)) : '0;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  // Wrapping event counters for pushes, stalled heads and redirects
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(push);
    perf_stall_d   = perf_stall_q + 32'(out_valid & ~out_ready);
    perf_flush_d   = perf_flush_q + 16'(redirect);
  end

  // Counter state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
      perf_flush_q   <= perf_flush_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit (default parameters): directed steps plus
// randomized traffic, checked against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        br_taken;
  logic [31:0] br_base_pc4;
  logic [15:0] br_imm16;
  logic        jump;
  logic [31:0] jump_base_pc4;
  logic [25:0] jump_tgt26;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  assign imem_rdata = rom(imem_addr);

  always #5 clock = ~clock;

  fetch_queue_unit dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc4       (out_pc4),
    .br_taken      (br_taken),
    .br_base_pc4   (br_base_pc4),
    .br_imm16      (br_imm16),
    .jump          (jump),
    .jump_base_pc4 (jump_base_pc4),
    .jump_tgt26    (jump_tgt26)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with the model
  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_pc4", out_pc4, mq[0].pc + 32'd4);
      chk("out_instr", out_instr, mq[0].instr);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_flush", 32'(perf_flush), 32'(m_flush));
`endif
  endtask

  // One clock: advance the model with the inputs present at the edge, then check
  task automatic tick();
    logic [31:0] btgt;
    logic [31:0] jtgt;
    bit          do_pop;
    bit          do_push;
    @(posedge clock);
    btgt = br_base_pc4 + ({{16{br_imm16[15]}}, br_imm16} << 2);
    jtgt = {jump_base_pc4[31:28], jump_tgt26, 2'b00};
    if (reset) begin
      m_pc = 32'h0;
      mq.delete();
      m_fetched = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      if (mq.size() != 0 && !out_ready) m_stall++;
      if (br_taken || jump) begin
        m_pc = jump ? jtgt : btgt;
        mq.delete();
        m_flush++;
      end else begin
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = (mq.size() < DEPTH) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{pc: m_pc, instr: rom(m_pc)});
          m_pc = m_pc + 32'd4;
          m_fetched++;
        end
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    br_taken = 1'b0; br_base_pc4 = '0; br_imm16 = '0;
    jump = 1'b0; jump_base_pc4 = '0; jump_tgt26 = '0;
    m_pc = 0; m_fetched = 0; m_stall = 0; m_flush = 0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Streaming with ready held high
    reset = 1'b0;
    tick();
    chk("t1_first_pc", out_pc, 32'h0);
    repeat (8) tick();

    // Backpressure from reset: queue fills, PC freezes at 0x10
    reset = 1'b1; tick();
    reset = 1'b0; out_ready = 1'b0;
    repeat (10) tick();
    chk("t2_addr_frozen", imem_addr, 32'h10);
    chk("t2_head_held", out_pc, 32'h0);
    out_ready = 1'b1;
    repeat (6) tick();

    // Taken branch with negative offset
    br_taken = 1'b1; br_base_pc4 = 32'h20; br_imm16 = 16'hFFFE;
    tick();
    br_taken = 1'b0;
    chk("t3_addr", imem_addr, 32'h18);
    chk("t3_bubble", 32'(out_valid), 32'h0);
    tick();
    chk("t3_target_pc", out_pc, 32'h18);
    repeat (3) tick();

    // Branch and jump together: jump wins
    br_taken = 1'b1; br_base_pc4 = 32'h40; br_imm16 = 16'h0010;
    jump = 1'b1; jump_base_pc4 = 32'h100; jump_tgt26 = 26'h40;
    tick();
    br_taken = 1'b0; jump = 1'b0;
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_flushed", 32'(out_valid), 32'h0);
    tick();
    chk("t4_target_pc", out_pc, 32'h100);
    repeat (2) tick();

    // PC wrap from the top of the address space
    jump = 1'b1; jump_base_pc4 = 32'hF000_0000; jump_tgt26 = 26'h3FF_FFFF;
    tick();
    jump = 1'b0;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_zero", imem_addr, 32'h0);
    tick();
    chk("wrap_head_zero", out_pc, 32'h0);

    // Redirect with a full queue, unaligned target
    out_ready = 1'b0;
    repeat (6) tick();
    br_taken = 1'b1; br_base_pc4 = 32'h203; br_imm16 = 16'h0005;
    tick();
    br_taken = 1'b0; out_ready = 1'b1;
    chk("full_redirect_addr", imem_addr, 32'h217);
    repeat (3) tick();

    // Reset mid-stream with a full queue
    out_ready = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    reset = 1'b0;

    // Randomized traffic
    repeat (400) begin
      int r;
      r = int'($urandom_range(0, 99));
      out_ready     = ($urandom_range(0, 3) != 0);
      br_taken      = (r < 4);
      jump          = (r >= 3 && r < 7);
      reset         = (r == 99);
      br_base_pc4   = $urandom();
      br_imm16      = 16'($urandom());
      jump_base_pc4 = $urandom();
      jump_tgt26    = 26'($urandom());
      tick();
    end
    br_taken = 1'b0; jump = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
